io_input_cond: RTL
==================

Name: io_input_cond

Overview:
Parametrised, synthesisable input-conditioning block for the board push-buttons and switches (the signals driving i_io_btn / i_io_sw of the core). It generalises the bench-side button stimulus into real hardware:
- N independent channels, each with a multi-stage synchroniser, a per-channel debounce FSM and edge detection.
- A sticky press-event register with clear-on-read semantics, plus an interrupt output.
- Sits between the top-level pins and the memory-mapped IO input path of the processor.

Parameters:
N_CH, 4, number of input channels
SYNC_STAGES, 2, synchroniser flops per channel (legal range 2..4)
DB_CYCLES, 16, consecutive stable synchronised samples required to accept a level change (minimum 1)
ACTIVE_LOW, 1, 1 = raw pin low means asserted (inverted before synchroniser output); 0 = active-high

Ports:
i_clk  in  1  system clock; all state on rising edge
i_rst  in  1  synchronous active-high reset
i_raw  in  N_CH  asynchronous raw pin levels
i_irq_en  in  N_CH  per-channel interrupt enable
i_evt_rd  in  1  one-cycle pulse: event register read, clears flags
o_level  out  N_CH  debounced logical level, 1 = asserted
o_rise  out  N_CH  one-cycle pulse when o_level goes 0->1
o_fall  out  N_CH  one-cycle pulse when o_level goes 1->0
o_evt  out  N_CH  sticky press flags, set by o_rise
o_irq  out  1  OR over channels of (o_evt & i_irq_en), registered

Behaviour:
- Reset:
  - Synchroniser flops load the deasserted logical value (0 after polarity handling).
  - All FSMs go to S_LO with counter 0.
  - o_level, o_rise, o_fall, o_evt and o_irq are all 0.
  - Reset wins over every other event in the same cycle.
- Polarity: logical input = ACTIVE_LOW ? ~raw : raw. The inversion is applied at synchroniser input, so the reset value means "released".
- Synchroniser: a plain shift chain of SYNC_STAGES flops. Its output s is the last stage.
- Per-channel FSM has four states, S_LO, S_CNT_HI, S_HI and S_CNT_LO. Counter width is clog2(DB_CYCLES+1).
  - S_LO: if s=1, go to S_CNT_HI with cnt=1. If DB_CYCLES=1, go directly to S_HI instead.
  - S_CNT_HI:
    - If s=0, go to S_LO with cnt=0 (glitch rejected, no output change).
    - Else, if cnt=DB_CYCLES-1, go to S_HI.
    - Else cnt++.
  - S_HI: mirror of S_LO, with s=0 moving to S_CNT_LO.
  - S_CNT_LO: mirror of S_CNT_HI. It returns to S_HI when s=1 and enters S_LO at the count limit.
- o_level is registered: 1 in S_HI and S_CNT_LO, else 0.
- Latency: raw change to o_level change is exactly SYNC_STAGES + DB_CYCLES rising edges, provided the raw level is held stable throughout.
- A pulse shorter than DB_CYCLES synchronised samples never changes o_level.
- o_rise / o_fall:
  - Registered, high for exactly one cycle.
  - Asserted in the same cycle o_level first shows the new value.
  - Never both high on one channel.
- o_evt:
  - Bit i is set on the edge that asserts o_rise[i].
  - All bits clear on an edge where i_evt_rd=1.
  - Set wins over clear on the same edge, per bit.
  - No other clearing mechanism.
- o_irq: registered; equals |(o_evt & i_irq_en) from the previous cycle, so it lags o_evt by one cycle.
- Channels are fully independent. Simultaneous edges on multiple channels are all reported in the same cycle.
- Reset mid-count discards the partial count. After reset release the full latency applies again.

Test Plan:
Configuration for all scenarios: N_CH=4, SYNC_STAGES=2, DB_CYCLES=4, ACTIVE_LOW=1, i_raw idle = 4'hF, i_irq_en = 4'h1.
1. Reset: i_rst=1 for 3 cycles with i_raw=4'h0 -> all outputs 0 during reset. After release with raw held 4'h0, o_level=4'hF exactly 6 edges later, with o_rise=4'hF for one cycle.
2. Press ch0: i_raw[0] 1->0 and held -> o_level[0]=1 and o_rise[0]=1 at edge 6 after the change. o_evt=4'h1 from the same cycle; o_irq=1 one cycle later.
3. Bounce on ch1: i_raw[1] low for 3 cycles, then high -> o_level, o_rise and o_evt on ch1 stay 0. Repeat with 4 cycles low -> accepted.
4. Release ch0: i_raw[0] 0->1 -> o_fall[0] pulses at edge 6 and o_level[0]=0. o_evt[0] stays 1.
5. Read/set collision: with o_evt=4'h1, assert i_evt_rd on the edge where o_rise[2] is asserted -> o_evt=4'h4 afterwards and o_irq=0 (ch2 not enabled).
6. Reset mid-count: i_raw[3] low, assert i_rst after 4 edges and release after 1 cycle with raw still low -> o_level[3] rises exactly 6 edges after reset release, not earlier.

Source files
------------

// File: rtl/io_input_cond.sv
// Push-button / switch input conditioning: per-channel synchroniser, debounce
// FSM, edge pulses, sticky clear-on-read press flags and a registered interrupt.
module io_input_cond #(
  parameter int unsigned N_CH        = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DB_CYCLES   = 16,
  parameter bit          ACTIVE_LOW  = 1'b1
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic [N_CH-1:0] i_raw,
  input  logic [N_CH-1:0] i_irq_en,
  input  logic            i_evt_rd,
  output logic [N_CH-1:0] o_level,
  output logic [N_CH-1:0] o_rise,
  output logic [N_CH-1:0] o_fall,
  output logic [N_CH-1:0] o_evt,
  output logic            o_irq
);

  localparam int unsigned CW = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  typedef enum logic [1:0] {
    S_LO     = 2'd0,
    S_CNT_HI = 2'd1,
    S_HI     = 2'd2,
    S_CNT_LO = 2'd3
  } state_e;

  logic [N_CH-1:0] raw_log;
  logic [N_CH-1:0] sync_q [SYNC_STAGES];
  logic [N_CH-1:0] sync_s;

  state_e          state_q [N_CH];
  state_e          state_d [N_CH];
  logic [CW-1:0]   cnt_q   [N_CH];
  logic [CW-1:0]   cnt_d   [N_CH];

  logic [N_CH-1:0] level_q, level_d;
  logic [N_CH-1:0] rise_q, rise_d;
  logic [N_CH-1:0] fall_q, fall_d;
  logic [N_CH-1:0] evt_q, evt_d;
  logic            irq_q, irq_d;

  // Inverting ahead of the chain makes the all-zero reset value mean "released".
  assign raw_log = ACTIVE_LOW ? ~i_raw : i_raw;
  assign sync_s  = sync_q[SYNC_STAGES-1];

  always_comb begin
    level_d = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      case (state_q[i])
        S_LO: begin
          if (sync_s[i]) begin
            if (DB_CYCLES == 1) begin
              state_d[i] = S_HI;
              cnt_d[i]   = '0;
            end else begin
              state_d[i] = S_CNT_HI;
              cnt_d[i]   = CNT_ONE;
            end
          end
        end
        S_CNT_HI: begin
          if (!sync_s[i]) begin
            state_d[i] = S_LO;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == CNT_LAST) begin
            state_d[i] = S_HI;
            cnt_d[i]   = '0;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_ONE;
          end
        end
        S_HI: begin
          if (!sync_s[i]) begin
            if (DB_CYCLES == 1) begin
              state_d[i] = S_LO;
              cnt_d[i]   = '0;
            end else begin
              state_d[i] = S_CNT_LO;
              cnt_d[i]   = CNT_ONE;
            end
          end
        end
        S_CNT_LO: begin
          if (sync_s[i]) begin
            state_d[i] = S_HI;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == CNT_LAST) begin
            state_d[i] = S_LO;
            cnt_d[i]   = '0;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_ONE;
          end
        end
        default: begin
          state_d[i] = S_LO;
          cnt_d[i]   = '0;
        end
      endcase
      // Level decoded from the next state so it updates on the accepting edge.
      level_d[i] = (state_d[i] == S_HI) || (state_d[i] == S_CNT_LO);
    end
    rise_d = level_d & ~level_q;
    fall_d = ~level_d & level_q;
    evt_d  = (evt_q & ~{N_CH{i_evt_rd}}) | rise_d;
    irq_d  = |(evt_q & i_irq_en);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int unsigned k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
      for (int unsigned i = 0; i < N_CH; i++) begin
        state_q[i] <= S_LO;
        cnt_q[i]   <= '0;
      end
      level_q <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
      evt_q   <= '0;
      irq_q   <= 1'b0;
    end else begin
      sync_q[0] <= raw_log;
      for (int unsigned k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
      for (int unsigned i = 0; i < N_CH; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      evt_q   <= evt_d;
      irq_q   <= irq_d;
    end
  end

  assign o_level = level_q;
  assign o_rise  = rise_q;
  assign o_fall  = fall_q;
  assign o_evt   = evt_q;
  assign o_irq   = irq_q;

endmodule
